// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle between the pipeline and the branch predictor.
// The master side is the pipeline (IF lookup, ID/EX resolution); the slave side is the predictor.
interface branch_predictor_if #(
   parameter int ADDR_W = 32
);
   logic              lookup_valid_i;
   logic [ADDR_W-1:0] pc_i;
   logic              pred_taken_o;
   logic [ADDR_W-1:0] pred_target_o;
   logic              hit_o;

   logic              upd_valid_i;
   logic              upd_is_branch_i;
   logic [ADDR_W-1:0] upd_pc_i;
   logic              upd_taken_i;
   logic [ADDR_W-1:0] upd_target_i;
   logic              upd_pred_taken_i;
   logic [ADDR_W-1:0] upd_pred_target_i;
   logic              mispredict_o;

   modport master (
      output lookup_valid_i, pc_i,
      output upd_valid_i, upd_is_branch_i, upd_pc_i, upd_taken_i, upd_target_i,
      output upd_pred_taken_i, upd_pred_target_i,
      input  pred_taken_o, pred_target_o, hit_o, mispredict_o
   );

   modport slave (
      input  lookup_valid_i, pc_i,
      input  upd_valid_i, upd_is_branch_i, upd_pc_i, upd_taken_i, upd_target_i,
      input  upd_pred_taken_i, upd_pred_target_i,
      output pred_taken_o, pred_target_o, hit_o, mispredict_o
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters; zero-latency lookup, updates land on the next edge.
// No backpressure: one lookup and one update accepted every cycle; mispredict is combinational.
module branch_predictor #(
   parameter int ADDR_W    = 32,
   parameter int ENTRIES   = 64,
   parameter int TAG_W     = 8,
   parameter int CTR_W     = 2,
   parameter int PRED_MODE = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   branch_predictor_if.slave bp,
   input  logic              clr_stats_i,
   output logic [31:0]       lookup_cnt_o,
   output logic [31:0]       mispred_cnt_o
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(2 ** (CTR_W - 1));

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [CTR_W-1:0]   ctr_q [ENTRIES];
   logic [ADDR_W-1:0]  tgt_q [ENTRIES];

   logic [IDX_W-1:0]   lk_idx;
   logic [TAG_W-1:0]   lk_tag;
   logic [IDX_W-1:0]   up_idx;
   logic [TAG_W-1:0]   up_tag;
   logic               lk_hit;
   logic               lk_taken;
   logic               up_en;
   logic               up_hit;
   logic               mispredict;
   logic               unused_pc;

   assign lk_idx = bp.pc_i[IDX_W+1:2];
   assign lk_tag = bp.pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign up_idx = bp.upd_pc_i[IDX_W+1:2];
   assign up_tag = bp.upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign unused_pc = ^{bp.pc_i, bp.upd_pc_i};

   // Lookup reads the flops directly, so a same-cycle update is only seen next cycle.
   assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_taken = (PRED_MODE != 0) && lk_hit && ctr_q[lk_idx][CTR_W-1];

   assign bp.hit_o         = lk_hit;
   assign bp.pred_taken_o  = lk_taken;
   assign bp.pred_target_o = lk_taken ? tgt_q[lk_idx] : bp.pc_i + ADDR_W'(4);

   assign up_en  = bp.upd_valid_i && bp.upd_is_branch_i;
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   assign mispredict = up_en &&
                       ((bp.upd_pred_taken_i != bp.upd_taken_i) ||
                        (bp.upd_taken_i && (bp.upd_pred_target_i != bp.upd_target_i)));
   assign bp.mispredict_o = mispredict;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
      end else if (up_en) begin
         if (up_hit) begin
            if (bp.upd_taken_i) begin
               tgt_q[up_idx] <= bp.upd_target_i;
               if (ctr_q[up_idx] != CTR_MAX) begin
                  ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
               end
            end else if (ctr_q[up_idx] != '0) begin
               ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
            end
         end else if (bp.upd_taken_i) begin
            // Not-taken misses never allocate: they would only displace useful entries.
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            tgt_q[up_idx]   <= bp.upd_target_i;
            ctr_q[up_idx]   <= CTR_WEAK;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_stats_i) begin
         lookup_cnt_o  <= '0;
         mispred_cnt_o <= '0;
      end else begin
         if (bp.lookup_valid_i) begin
            lookup_cnt_o <= lookup_cnt_o + 32'd1;
         end
         if (mispredict) begin
            mispred_cnt_o <= mispred_cnt_o + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a static-not-taken instance share one stimulus stream,
// each cycle's expectations come from a small BTB model and are scoreboarded against both.
module tb_branch_predictor;
   logic        clk = 1'b0;
   logic        rst;
   logic        clr_stats;
   logic [31:0] lcnt, mcnt, lcnt0, mcnt0;

   int vectors     = 0;
   int miscompares = 0;

   branch_predictor_if #(.ADDR_W(32)) bpi ();
   branch_predictor_if #(.ADDR_W(32)) bpi0 ();

   assign bpi0.lookup_valid_i    = bpi.lookup_valid_i;
   assign bpi0.pc_i              = bpi.pc_i;
   assign bpi0.upd_valid_i       = bpi.upd_valid_i;
   assign bpi0.upd_is_branch_i   = bpi.upd_is_branch_i;
   assign bpi0.upd_pc_i          = bpi.upd_pc_i;
   assign bpi0.upd_taken_i       = bpi.upd_taken_i;
   assign bpi0.upd_target_i      = bpi.upd_target_i;
   assign bpi0.upd_pred_taken_i  = bpi.upd_pred_taken_i;
   assign bpi0.upd_pred_target_i = bpi.upd_pred_target_i;

   branch_predictor #(.PRED_MODE(1)) dut (
      .clk_i(clk), .rst_i(rst), .bp(bpi),
      .clr_stats_i(clr_stats), .lookup_cnt_o(lcnt), .mispred_cnt_o(mcnt)
   );

   branch_predictor #(.PRED_MODE(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .bp(bpi0),
      .clr_stats_i(clr_stats), .lookup_cnt_o(lcnt0), .mispred_cnt_o(mcnt0)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;

   sb_t sb_q[$];

   logic        m_valid [64];
   logic [7:0]  m_tag   [64];
   int          m_ctr   [64];
   logic [31:0] m_tgt   [64];
   logic [31:0] m_lcnt;
   logic [31:0] m_mcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         0:  return {31'd0, bpi.hit_o};
         1:  return {31'd0, bpi.pred_taken_o};
         2:  return bpi.pred_target_o;
         3:  return {31'd0, bpi.mispredict_o};
         4:  return lcnt;
         5:  return mcnt;
         6:  return {31'd0, bpi0.hit_o};
         7:  return {31'd0, bpi0.pred_taken_o};
         8:  return bpi0.pred_target_o;
         9:  return {31'd0, bpi0.mispredict_o};
         10: return lcnt0;
         default: return mcnt0;
      endcase
   endfunction

   function automatic void push(input string tag, input int sel, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      m_lcnt = '0;
      m_mcnt = '0;
   endtask

   // One clock: drive, push model expectations, compare at negedge, then advance the model.
   task automatic cyc(input string name, input logic r, input logic clr, input logic lv,
                      input logic [31:0] pc, input logic uv, input logic ub,
                      input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                      input logic upt, input logic [31:0] uptgt);
      int          li, ui;
      logic        mh, mt, uh, mp;
      logic [31:0] mtgt;
      sb_t         e;

      rst = r; clr_stats = clr;
      bpi.lookup_valid_i = lv;  bpi.pc_i = pc;
      bpi.upd_valid_i = uv;     bpi.upd_is_branch_i = ub;
      bpi.upd_pc_i = upc;       bpi.upd_taken_i = ut;
      bpi.upd_target_i = utgt;  bpi.upd_pred_taken_i = upt;
      bpi.upd_pred_target_i = uptgt;

      li   = int'(pc[7:2]);
      mh   = m_valid[li] && (m_tag[li] == pc[15:8]);
      mt   = mh && (m_ctr[li] >= 2);
      mtgt = mt ? m_tgt[li] : pc + 32'd4;
      mp   = uv && ub && ((upt != ut) || (ut && (uptgt != utgt)));

      push({name, "/hit"}, 0, {31'd0, mh});
      push({name, "/taken"}, 1, {31'd0, mt});
      push({name, "/target"}, 2, mtgt);
      push({name, "/mispred"}, 3, {31'd0, mp});
      push({name, "/lcnt"}, 4, m_lcnt);
      push({name, "/mcnt"}, 5, m_mcnt);
      push({name, "/hit0"}, 6, {31'd0, mh});
      push({name, "/taken0"}, 7, 32'd0);
      push({name, "/target0"}, 8, pc + 32'd4);
      push({name, "/mispred0"}, 9, {31'd0, mp});
      push({name, "/lcnt0"}, 10, m_lcnt);
      push({name, "/mcnt0"}, 11, m_mcnt);

      @(negedge clk);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, observe(e.sel), e.exp);
      end

      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         if (uv && ub) begin
            ui = int'(upc[7:2]);
            uh = m_valid[ui] && (m_tag[ui] == upc[15:8]);
            if (uh) begin
               if (ut) begin
                  m_tgt[ui] = utgt;
                  if (m_ctr[ui] < 3) m_ctr[ui]++;
               end else if (m_ctr[ui] > 0) begin
                  m_ctr[ui]--;
               end
            end else if (ut) begin
               m_valid[ui] = 1'b1;
               m_tag[ui]   = upc[15:8];
               m_tgt[ui]   = utgt;
               m_ctr[ui]   = 2;
            end
         end
         if (clr) begin
            m_lcnt = '0;
            m_mcnt = '0;
         end else begin
            if (lv) m_lcnt = m_lcnt + 32'd1;
            if (mp) m_mcnt = m_mcnt + 32'd1;
         end
      end
      #1;
   endtask

   task automatic look(input string name, input logic [31:0] pc);
      cyc(name, 1'b0, 1'b0, 1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic upd(input string name, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
      cyc(name, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, upc, ut, utgt, upt, uptgt);
   endtask

   initial begin
      logic [31:0] pcs [5];
      pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h4040; pcs[3] = 32'hC0; pcs[4] = 32'h2044;

      rst = 1'b1; clr_stats = 1'b0;
      bpi.lookup_valid_i = 1'b0; bpi.pc_i = '0;
      bpi.upd_valid_i = 1'b0; bpi.upd_is_branch_i = 1'b0; bpi.upd_pc_i = '0;
      bpi.upd_taken_i = 1'b0; bpi.upd_target_i = '0;
      bpi.upd_pred_taken_i = 1'b0; bpi.upd_pred_target_i = '0;
      @(posedge clk);
      model_reset();
      #1;

      cyc("rst_hold", 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      look("post_rst", 32'h40);

      upd("alloc40", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
      look("hit40", 32'h40);

      upd("sat1", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      upd("sat2", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      upd("sat3", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      upd("nt1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
      look("still_taken", 32'h40);
      upd("nt2", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
      look("now_nt", 32'h40);

      upd("alias", 32'h4040, 1'b1, 32'h200, 1'b0, 32'h0);
      look("alias_old", 32'h40);
      look("alias_new", 32'h4040);

      cyc("hazard", 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 1'b1, 32'h300, 1'b1, 32'h300);
      look("hazard_next", 32'h80);
      upd("bad_target", 32'h80, 1'b1, 32'h310, 1'b1, 32'h300);
      look("new_target", 32'h80);

      cyc("non_branch", 1'b0, 1'b0, 1'b1, 32'hC0, 1'b1, 1'b0, 32'hC0, 1'b1, 32'h400, 1'b0, 32'h0);
      look("non_branch_miss", 32'hC0);

      cyc("clr", 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h310);
      look("after_clr", 32'h80);

      cyc("rst_upd", 1'b1, 1'b0, 1'b1, 32'hC0, 1'b1, 1'b1, 32'hC0, 1'b1, 32'h500, 1'b0, 32'h0);
      look("rst_dropped", 32'hC0);
      look("rst_cleared", 32'h4040);

      for (int n = 0; n < 300; n++) begin
         cyc("rand", 1'b0, ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
             pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 3) * 16), 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 3) * 16));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
